// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 16-bit five-stage pipelined CPU. Holds the
//   PC, picks the next PC (sequential / branch redirect / stall / halt), drives
//   the instruction-memory address and registers the fetched instruction plus
//   PC+2 into the IF/ID buffer with hold and flush. HALTED is absorbing; only
//   reset leaves it.
//
// Ports
//   clock              in   rising-edge clock
//   reset              in   synchronous active-high reset (top priority)
//   imem_addr          out  instruction-memory address (= current PC)
//   imem_data          in   instruction word from combinational imem
//   pc_stop            in   hazard stall: hold PC and IF/ID buffer
//   if_id_flush        in   bubble the IF/ID buffer
//   branch_taken       in   redirect PC to branch_target
//   branch_target      in   redirect address (bit 0 is dropped)
//   halt_req           in   HALT decoded by the control unit
//   id_instruction     out  IF/ID buffered instruction
//   id_pc_next_address out  IF/ID buffered PC+2
//   id_valid           out  IF/ID buffer holds a real instruction
//   halted             out  fetch frozen in HALTED
//   misaligned_target  out  sticky: an odd branch target was received
//
// Optional feature macro: IF_PERF_COUNT_EN
//   When defined, adds fetch_count and stall_count (32-bit, saturating,
//   cleared on reset, frozen in HALTED).
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int                      ADDR_WIDTH  = 16,
    parameter int                      INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = 16'h0000,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 16'h0000
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic [INSTR_WIDTH-1:0]  imem_data,
    input  logic                    pc_stop,
    input  logic                    if_id_flush,
    input  logic                    branch_taken,
    input  logic [ADDR_WIDTH-1:0]   branch_target,
    input  logic                    halt_req,
    output logic [INSTR_WIDTH-1:0]  id_instruction,
    output logic [ADDR_WIDTH-1:0]   id_pc_next_address,
    output logic                    id_valid,
    output logic                    halted,
    output logic                    misaligned_target
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0]             fetch_count,
    output logic [31:0]             stall_count
`endif
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2'd2);

    state_t                   state_r;
    state_t                   state_next_s;
    logic [ADDR_WIDTH-1:0]    pc_r;
    logic [ADDR_WIDTH-1:0]    pc_next_s;
    logic [ADDR_WIDTH-1:0]    pc_plus2_s;
    logic [INSTR_WIDTH-1:0]   id_instr_r;
    logic [INSTR_WIDTH-1:0]   id_instr_next_s;
    logic [ADDR_WIDTH-1:0]    id_pcn_r;
    logic [ADDR_WIDTH-1:0]    id_pcn_next_s;
    logic                     id_valid_r;
    logic                     id_valid_next_s;
    logic                     mis_r;
    logic                     mis_next_s;
    logic                     load_s;
    logic                     stall_evt_s;

    assign pc_plus2_s = pc_r + PC_STEP;

    // Next-state, next-PC and IF/ID buffer selection for the current cycle
    always_comb begin
        state_next_s    = state_r;
        pc_next_s       = pc_r;
        id_instr_next_s = id_instr_r;
        id_pcn_next_s   = id_pcn_r;
        id_valid_next_s = id_valid_r;
        mis_next_s      = mis_r;
        load_s          = 1'b0;
        stall_evt_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (halt_req) begin
                    // PC and id_pc_next_address hold; only the instruction is bubbled
                    state_next_s    = ST_HALTED;
                    id_instr_next_s = NOP_INSTR;
                    id_valid_next_s = 1'b0;
                end else if (branch_taken) begin
                    // Redirect beats stall; the word fetched this cycle is wrong-path
                    pc_next_s       = {branch_target[ADDR_WIDTH-1:1], 1'b0};
                    mis_next_s      = mis_r | branch_target[0];
                    id_instr_next_s = NOP_INSTR;
                    id_valid_next_s = 1'b0;
                end else if (pc_stop) begin
                    stall_evt_s = 1'b1;
                    if (if_id_flush) begin
                        id_instr_next_s = NOP_INSTR;
                        id_valid_next_s = 1'b0;
                    end else begin
                        id_instr_next_s = id_instr_r;
                    end
                end else begin
                    pc_next_s = pc_plus2_s;
                    if (if_id_flush) begin
                        id_instr_next_s = NOP_INSTR;
                        id_valid_next_s = 1'b0;
                    end else begin
                        id_instr_next_s = imem_data;
                        id_pcn_next_s   = pc_plus2_s;
                        id_valid_next_s = 1'b1;
                        load_s          = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                // Frozen: every request input is ignored until reset
                state_next_s = ST_HALTED;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // State, PC, IF/ID buffer and sticky flag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            id_instr_r <= NOP_INSTR;
            id_pcn_r   <= '0;
            id_valid_r <= 1'b0;
            mis_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            id_instr_r <= id_instr_next_s;
            id_pcn_r   <= id_pcn_next_s;
            id_valid_r <= id_valid_next_s;
            mis_r      <= mis_next_s;
        end
    end

    assign imem_addr          = pc_r;
    assign id_instruction     = id_instr_r;
    assign id_pc_next_address = id_pcn_r;
    assign id_valid           = id_valid_r;
    assign halted             = (state_r == ST_HALTED);
    assign misaligned_target  = mis_r;

`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] stall_cnt_r;

    // Saturating performance counters; they only move in RUN
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt_r <= 32'h0000_0000;
            stall_cnt_r <= 32'h0000_0000;
        end else begin
            if (load_s && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
                fetch_cnt_r <= fetch_cnt_r + 32'h0000_0001;
            end
            if (stall_evt_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
            end
        end
    end

    assign fetch_count = fetch_cnt_r;
    assign stall_count = stall_cnt_r;
`else
    logic unused_perf_s;
    assign unused_perf_s = load_s ^ stall_evt_s;
`endif

endmodule
